// File: rtl/key_debounce_pkg.sv
// Shared constants and helpers for the four-key debouncer.
// Read by key_debounce and key_debounce_bit.
package key_debounce_pkg;

    localparam int KEY_W        = 4;
    localparam int CLK_FREQ_MHZ = 50;

    // These give 20 ms of settling and a 500 ms autorepeat period at CLK_FREQ_MHZ.
    localparam int DEF_DEBOUNCE_CYCLES = 20 * 1000 * CLK_FREQ_MHZ;
    localparam int DEF_REPEAT_CYCLES   = 500 * 1000 * CLK_FREQ_MHZ;

    function automatic int cnt_width(input int debounce_cycles, input int repeat_cycles);
        int max_cycles;
        max_cycles = (debounce_cycles > repeat_cycles) ? debounce_cycles : repeat_cycles;
        return (max_cycles < 2) ? 1 : $clog2(max_cycles);
    endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// One key channel: a two-flop synchronizer, a stability counter and the accepted level.
// key_pressed is the accepted level inverted, so 1 means the button is held down.
module key_debounce_bit
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_pressed
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Every flop resets to the released level, so no edge is seen after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
            level  <= 1'b1;
            cnt    <= '0;
        end else begin
            sync_a <= key_raw;
            sync_b <= sync_a;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_b;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign key_pressed = ~level;

endmodule

// File: rtl/key_debounce.sv
// Debounces four active-low push-buttons. strobe_o pulses in the cycle key_o changes.
// Define KEY_DEBOUNCE_AUTOREPEAT_EN to get extra strobes every REPEAT_CYCLES while a key is held.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic             clk50m_i,
    input  logic             rst_n_i,
    input  logic [KEY_W-1:0] key_i,
    output logic [KEY_W-1:0] key_o,
    output logic             strobe_o
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);

    logic [KEY_W-1:0] key_state;
    logic [KEY_W-1:0] key_prev;
    logic             change;

    for (genvar i = 0; i < KEY_W; i++) begin : g_bit
        key_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_bit (
            .clk        (clk50m_i),
            .rst_n      (rst_n_i),
            .key_raw    (key_i[i]),
            .key_pressed(key_state[i])
        );
    end

    // key_prev resets to the same value as key_state, so release produces no strobe.
    always_ff @(posedge clk50m_i) begin
        if (!rst_n_i) begin
            key_prev <= '0;
        end else begin
            key_prev <= key_state;
        end
    end

    // Bits that settle on the same edge show up as one combined change.
    assign change = (key_state != key_prev);

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] rpt_cnt;
    logic             rpt_hit;

    assign rpt_hit = (key_state != '0) && !change && (rpt_cnt == RPT_LAST);

    always_ff @(posedge clk50m_i) begin
        if (!rst_n_i || change || (key_state == '0) || rpt_hit) begin
            rpt_cnt <= '0;
        end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
        end
    end

    assign strobe_o = change | rpt_hit;
`else
    assign strobe_o = change;
`endif

    assign key_o = key_state;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=4 and REPEAT_CYCLES=10.
// Stimulus queues each expected strobe (cycle, key_o); the monitor pops one per strobe_o.
module tb_key_debounce;

    localparam int DEB = 4;
    localparam int RPT = 10;

    logic       clk50m = 1'b0;
    logic       rst_n  = 1'b0;
    logic [3:0] key    = 4'hF;
    logic [3:0] key_q;
    logic       strobe;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         at;
        logic [3:0] k;
    } exp_t;

    exp_t sb[$];

    key_debounce #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_CYCLES  (RPT)
    ) dut (
        .clk50m_i(clk50m),
        .rst_n_i (rst_n),
        .key_i   (key),
        .key_o   (key_q),
        .strobe_o(strobe)
    );

    always #10 clk50m = ~clk50m;

    always @(posedge clk50m) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk50m);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: key_o=%h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic expect_strobe(input int at, input logic [3:0] k);
        exp_t e;
        e.at = at;
        e.k  = k;
        sb.push_back(e);
    endtask

    always @(negedge clk50m) begin
        if (strobe !== 1'b0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: strobe_o=%b key_o=%h at cycle %0d, none expected",
                         strobe, key_q, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.at != cyc || key_q !== e.k) begin
                    errors++;
                    $display("FAIL strobe: cycle %0d key_o=%h, expected cycle %0d key_o=%h",
                             cyc, key_q, e.at, e.k);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;

        // Reset with all keys released.
        rst_n = 1'b0;
        key   = 4'hF;
        tick(3);
        check("reset_key", key_q, 4'h0);
        checks++;
        if (strobe !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobe: strobe_o=%b expected 0", strobe);
        end
        rst_n = 1'b1;
        tick(12);
        check("idle_key", key_q, 4'h0);

        // Single key press and release.
        c   = cyc;
        key = 4'hE;
        expect_strobe(c + 6, 4'h1);
        tick(5);
        check("press_early", key_q, 4'h0);
        tick(1);
        check("press_settle", key_q, 4'h1);
        tick(2);
        c   = cyc;
        key = 4'hF;
        expect_strobe(c + 6, 4'h0);
        tick(5);
        check("release_early", key_q, 4'h1);
        tick(1);
        check("release_settle", key_q, 4'h0);
        tick(4);

        // Bounce on bit 0 with runs shorter than the debounce window.
        for (int i = 0; i < 5; i++) begin
            key = 4'hE;
            tick(2);
            key = 4'hF;
            tick(2);
        end
        tick(10);
        check("bounce_key", key_q, 4'h0);

        // All four keys at once: one strobe each way.
        c   = cyc;
        key = 4'h0;
        expect_strobe(c + 6, 4'hF);
        tick(6);
        check("all_press", key_q, 4'hF);
        tick(2);
        c   = cyc;
        key = 4'hF;
        expect_strobe(c + 6, 4'h0);
        tick(6);
        check("all_release", key_q, 4'h0);
        tick(4);

        // Reset pulse in the middle of a debounce discards the partial count.
        c   = cyc;
        key = 4'hE;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("midreset_key", key_q, 4'h0);
        c = cyc;
        expect_strobe(c + 6, 4'h1);
        tick(5);
        check("midreset_early", key_q, 4'h0);
        tick(1);
        check("midreset_settle", key_q, 4'h1);
        tick(2);
        c   = cyc;
        key = 4'hF;
        expect_strobe(c + 6, 4'h0);
        tick(6);
        check("midreset_release", key_q, 4'h0);
        tick(4);

        // Bits settling on consecutive edges, then together.
        c   = cyc;
        key = 4'hE;
        expect_strobe(c + 6, 4'h1);
        tick(1);
        key = 4'hC;
        expect_strobe(c + 7, 4'h3);
        tick(8);
        check("consec_key", key_q, 4'h3);
        c   = cyc;
        key = 4'hF;
        expect_strobe(c + 6, 4'h0);
        tick(6);
        check("consec_release", key_q, 4'h0);
        tick(4);

        // Long hold of bit 2, then reset while held: key_o drops with no strobe.
        c   = cyc;
        key = 4'hB;
        expect_strobe(c + 6, 4'h4);
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
        expect_strobe(c + 16, 4'h4);
        expect_strobe(c + 26, 4'h4);
        expect_strobe(c + 36, 4'h4);
`endif
        tick(40);
        check("hold_key", key_q, 4'h4);
        key   = 4'hF;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("hold_reset_key", key_q, 4'h0);
        tick(12);
        check("final_key", key_q, 4'h0);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_strobes: %0d expected strobes never seen, next due at cycle %0d",
                     sb.size(), sb[0].at);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
